// File: rtl/pipelined_control_unit_if.sv
// ID-side request/handshake and per-stage control outputs of pipelined_control_unit.
// master = ID stage / environment, slave = control unit.
interface pipelined_control_unit_if #(
  parameter int ALU_OP_W = 5
);
  logic                id_valid;
  logic                id_ready;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7_b5;
  logic                mul_inst;
  logic                flush;
  logic                ex_valid;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_branch_inst;
  logic                ex_jump_inst;
  logic                ex_reg_reg_inst;
  logic                ex_illegal;
  logic                mem_valid;
  logic                mem_load_inst;
  logic                mem_store_inst;
  logic                mem_reg_write;
  logic                wb_valid;
  logic                wb_load_inst;
  logic                wb_reg_write;
  logic                mc_busy;

  modport master (
    output id_valid, opcode, funct3, funct7_b5, mul_inst, flush,
    input  id_ready, ex_valid, ex_alu_op, ex_branch_inst, ex_jump_inst,
           ex_reg_reg_inst, ex_illegal, mem_valid, mem_load_inst,
           mem_store_inst, mem_reg_write, wb_valid, wb_load_inst,
           wb_reg_write, mc_busy
  );

  modport slave (
    input  id_valid, opcode, funct3, funct7_b5, mul_inst, flush,
    output id_ready, ex_valid, ex_alu_op, ex_branch_inst, ex_jump_inst,
           ex_reg_reg_inst, ex_illegal, mem_valid, mem_load_inst,
           mem_store_inst, mem_reg_write, wb_valid, wb_load_inst,
           wb_reg_write, mc_busy
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32IM control decode carried through EX/MEM/WB with multi-cycle MUL/DIV stall and flush.
// Optional feature: define CU_DIV_EN to decode DIV (DIV_CYCLES occupancy); otherwise DIV is illegal.
module pipelined_control_unit #(
  parameter int ALU_OP_W   = 5,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  pipelined_control_unit_if.slave   bus
);

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOP   = ALU_OP_W'(0),
    OP_ADD   = ALU_OP_W'(1),
    OP_SUB   = ALU_OP_W'(2),
    OP_XOR   = ALU_OP_W'(3),
    OP_OR    = ALU_OP_W'(4),
    OP_AND   = ALU_OP_W'(5),
    OP_SLL   = ALU_OP_W'(6),
    OP_SRL   = ALU_OP_W'(7),
    OP_SRA   = ALU_OP_W'(8),
    OP_SLT   = ALU_OP_W'(9),
    OP_SLTU  = ALU_OP_W'(10),
    OP_AUI   = ALU_OP_W'(11),
    OP_AUIPC = ALU_OP_W'(12),
    OP_MUL   = ALU_OP_W'(13),
    OP_DIV   = ALU_OP_W'(14)
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                branch;
    logic                jump;
    logic                reg_reg;
    logic                illegal;
    logic                load;
    logic                store;
    logic                reg_write;
    logic                is_mul;
    logic                is_div;
  } ctl_t;

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC - 1) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 2) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 2) ? DIV_CYCLES - 2 : 0);
  localparam logic MUL_STALLS = (MUL_CYCLES > 1);
  localparam logic DIV_STALLS = (DIV_CYCLES > 1);

  ctl_t             dec;
  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             capture, start_mc, hold_ex, mem_bubble;

  logic                ex_valid_q, ex_branch_q, ex_jump_q, ex_reg_reg_q, ex_illegal_q;
  logic                ex_load_q, ex_store_q, ex_reg_write_q;
  logic [ALU_OP_W-1:0] ex_alu_op_q;
  logic                mem_valid_q, mem_load_q, mem_store_q, mem_reg_write_q;
  logic                wb_valid_q, wb_load_q, wb_reg_write_q;

  always_comb begin
    dec        = '0;
    dec.alu_op = OP_NOP;
    if (bus.opcode[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (bus.opcode)
        7'b0000011: begin
          dec.load      = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = OP_ADD;
        end
        7'b0010011: begin
          dec.reg_write = 1'b1;
          unique case (bus.funct3)
            3'b000:  dec.alu_op = OP_ADD;
            3'b001:  dec.alu_op = OP_SLL;
            3'b010:  dec.alu_op = OP_SLT;
            3'b011:  dec.alu_op = OP_SLTU;
            3'b100:  dec.alu_op = OP_XOR;
            3'b101:  dec.alu_op = bus.funct7_b5 ? OP_SRA : OP_SRL;
            3'b110:  dec.alu_op = OP_OR;
            default: dec.alu_op = OP_AND;
          endcase
        end
        7'b0010111: begin
          dec.alu_op    = OP_AUIPC;
          dec.reg_write = 1'b1;
        end
        7'b0110111: begin
          dec.alu_op    = OP_AUI;
          dec.reg_write = 1'b1;
        end
        7'b0100011: begin
          dec.store  = 1'b1;
          dec.alu_op = OP_ADD;
        end
        7'b0110011: begin
          if (!bus.mul_inst) begin
            dec.reg_reg   = 1'b1;
            dec.reg_write = 1'b1;
            unique case (bus.funct3)
              3'b000:  dec.alu_op = bus.funct7_b5 ? OP_SUB : OP_ADD;
              3'b001:  dec.alu_op = OP_SLL;
              3'b010:  dec.alu_op = OP_SLT;
              3'b011:  dec.alu_op = OP_SLTU;
              3'b100:  dec.alu_op = OP_XOR;
              3'b101:  dec.alu_op = bus.funct7_b5 ? OP_SRA : OP_SRL;
              3'b110:  dec.alu_op = OP_OR;
              default: dec.alu_op = OP_AND;
            endcase
          end else if (bus.funct3 == 3'b000) begin
            dec.alu_op    = OP_MUL;
            dec.reg_reg   = 1'b1;
            dec.reg_write = 1'b1;
            dec.is_mul    = 1'b1;
`ifdef CU_DIV_EN
          end else if (bus.funct3 == 3'b100) begin
            dec.alu_op    = OP_DIV;
            dec.reg_reg   = 1'b1;
            dec.reg_write = 1'b1;
            dec.is_div    = 1'b1;
`endif
          end else begin
            dec.illegal = 1'b1;
          end
        end
        7'b1100011: begin
          dec.branch = 1'b1;
          dec.alu_op = OP_SUB;
        end
        7'b1101111, 7'b1100111: begin
          dec.jump      = 1'b1;
          dec.alu_op    = OP_ADD;
          dec.reg_write = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // In BUSY the final (cnt == 0) cycle releases EX into MEM unless a flush kills it.
  always_comb begin
    capture    = bus.id_valid && (state == S_IDLE) && !bus.flush;
    start_mc   = capture && ((dec.is_mul && MUL_STALLS) || (dec.is_div && DIV_STALLS));
    hold_ex    = (state == S_BUSY) && (cnt != '0) && !bus.flush;
    mem_bubble = (state == S_BUSY) && ((cnt != '0) || bus.flush);
    state_n    = state;
    cnt_n      = cnt;
    if (bus.flush) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_mc) begin
            state_n = S_BUSY;
            cnt_n   = dec.is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        default: begin
          if (cnt == '0) state_n = S_IDLE;
          else           cnt_n   = cnt - CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_alu_op_q    <= OP_NOP;
      ex_branch_q    <= 1'b0;
      ex_jump_q      <= 1'b0;
      ex_reg_reg_q   <= 1'b0;
      ex_illegal_q   <= 1'b0;
      ex_load_q      <= 1'b0;
      ex_store_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else if (!hold_ex) begin
      ex_valid_q     <= capture;
      ex_alu_op_q    <= capture ? dec.alu_op : OP_NOP;
      ex_branch_q    <= capture && dec.branch;
      ex_jump_q      <= capture && dec.jump;
      ex_reg_reg_q   <= capture && dec.reg_reg;
      ex_illegal_q   <= capture && dec.illegal;
      ex_load_q      <= capture && dec.load;
      ex_store_q     <= capture && dec.store;
      ex_reg_write_q <= capture && dec.reg_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_q     <= 1'b0;
      mem_load_q      <= 1'b0;
      mem_store_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_load_q       <= 1'b0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      mem_valid_q     <= ex_valid_q     && !mem_bubble;
      mem_load_q      <= ex_load_q      && !mem_bubble;
      mem_store_q     <= ex_store_q     && !mem_bubble;
      mem_reg_write_q <= ex_reg_write_q && !mem_bubble;
      wb_valid_q      <= mem_valid_q;
      wb_load_q       <= mem_load_q;
      wb_reg_write_q  <= mem_reg_write_q;
    end
  end

  assign bus.id_ready        = (state == S_IDLE);
  assign bus.mc_busy         = (state == S_BUSY);
  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_alu_op       = ex_alu_op_q;
  assign bus.ex_branch_inst  = ex_branch_q;
  assign bus.ex_jump_inst    = ex_jump_q;
  assign bus.ex_reg_reg_inst = ex_reg_reg_q;
  assign bus.ex_illegal      = ex_illegal_q;
  assign bus.mem_valid       = mem_valid_q;
  assign bus.mem_load_inst   = mem_load_q;
  assign bus.mem_store_inst  = mem_store_q;
  assign bus.mem_reg_write   = mem_reg_write_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_load_inst    = wb_load_q;
  assign bus.wb_reg_write    = wb_reg_write_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit (MUL_CYCLES = 3, DIV_CYCLES = 16).
module tb_pipelined_control_unit;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int A_NOP = 0, A_ADD = 1, A_SUB = 2, A_SRA = 8, A_AUI = 11, A_MUL = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipelined_control_unit_if #(.ALU_OP_W(5)) bus ();

  pipelined_control_unit #(
    .ALU_OP_W  (5),
    .MUL_CYCLES(3),
    .DIV_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic b5, input logic mul, input logic fl);
    bus.id_valid  = v;
    bus.opcode    = opc;
    bus.funct3    = f3;
    bus.funct7_b5 = b5;
    bus.mul_inst  = mul;
    bus.flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) tick();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_alu_op", bus.ex_alu_op, A_NOP);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_mc_busy", bus.mc_busy, 0);
    chk("rst_id_ready", bus.id_ready, 1);
    #3 reset = 1'b1;
    tick();

    // ADD through the pipe
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("add_id_ready", bus.id_ready, 1);
    tick(); idle();
    chk("add_ex_valid", bus.ex_valid, 1);
    chk("add_ex_op", bus.ex_alu_op, A_ADD);
    chk("add_ex_rr", bus.ex_reg_reg_inst, 1);
    chk("add_ex_ill", bus.ex_illegal, 0);
    tick();
    chk("add_mem_rw", bus.mem_reg_write, 1);
    chk("add_ex_bubble", bus.ex_valid, 0);
    tick();
    chk("add_wb_rw", bus.wb_reg_write, 1);
    chk("add_wb_valid", bus.wb_valid, 1);
    chk("add_mem_gone", bus.mem_valid, 0);
    tick();

    // MUL followed by ADD held on id_valid
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("mul_b1_ready", bus.id_ready, 0);
    chk("mul_b1_busy", bus.mc_busy, 1);
    chk("mul_b1_op", bus.ex_alu_op, A_MUL);
    chk("mul_b1_mem", bus.mem_valid, 0);
    tick();
    chk("mul_b2_ready", bus.id_ready, 0);
    chk("mul_b2_busy", bus.mc_busy, 1);
    chk("mul_b2_op", bus.ex_alu_op, A_MUL);
    chk("mul_b2_mem", bus.mem_valid, 0);
    tick();
    chk("mul_done_ready", bus.id_ready, 1);
    chk("mul_done_busy", bus.mc_busy, 0);
    chk("mul_mem_valid", bus.mem_valid, 1);
    chk("mul_mem_rw", bus.mem_reg_write, 1);
    chk("mul_ex_bubble", bus.ex_valid, 0);
    tick(); idle();
    chk("add2_ex_op", bus.ex_alu_op, A_ADD);
    chk("add2_ex_valid", bus.ex_valid, 1);
    chk("mul_wb_valid", bus.wb_valid, 1);
    chk("add2_mem_pending", bus.mem_valid, 0);
    tick();
    chk("add2_mem_valid", bus.mem_valid, 1);
    repeat (2) tick();

    // Async reset during BUSY
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    chk("rmid_busy_before", bus.mc_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rmid_busy", bus.mc_busy, 0);
    chk("rmid_ready", bus.id_ready, 1);
    chk("rmid_ex_valid", bus.ex_valid, 0);
    chk("rmid_alu_op", bus.ex_alu_op, A_NOP);
    chk("rmid_mem_valid", bus.mem_valid, 0);
    reset = 1'b1;
    tick();
    chk("rrel_ready", bus.id_ready, 1);
    chk("rrel_ex_valid", bus.ex_valid, 0);
    chk("rrel_busy", bus.mc_busy, 0);

    // Flush in first BUSY cycle
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    chk("fl1_busy_before", bus.mc_busy, 1);
    tick(); idle();
    chk("fl1_ex_valid", bus.ex_valid, 0);
    chk("fl1_busy", bus.mc_busy, 0);
    chk("fl1_ready", bus.id_ready, 1);
    chk("fl1_mem_valid", bus.mem_valid, 0);
    tick();
    chk("fl1_mem_never", bus.mem_valid, 0);
    chk("fl1_wb_never", bus.wb_valid, 0);

    // Flush coinciding with BUSY completion
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    tick();
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b0, 1'b1);
    tick(); idle();
    chk("fl2_mem_valid", bus.mem_valid, 0);
    chk("fl2_ex_valid", bus.ex_valid, 0);
    chk("fl2_busy", bus.mc_busy, 0);

    // Flush beats id_valid in IDLE
    drive(1'b1, OPC_OP, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("fl3_ready", bus.id_ready, 1);
    tick(); idle();
    chk("fl3_ex_valid", bus.ex_valid, 0);
    tick();

    // Store then load
    drive(1'b1, OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("st_ex_op", bus.ex_alu_op, A_ADD);
    tick(); idle();
    chk("st_mem_store", bus.mem_store_inst, 1);
    chk("st_mem_rw", bus.mem_reg_write, 0);
    chk("st_mem_load", bus.mem_load_inst, 0);
    tick();
    chk("ld_mem_load", bus.mem_load_inst, 1);
    chk("ld_mem_rw", bus.mem_reg_write, 1);
    chk("st_wb_rw", bus.wb_reg_write, 0);
    chk("st_wb_valid", bus.wb_valid, 1);
    tick();
    chk("ld_wb_load", bus.wb_load_inst, 1);
    chk("ld_wb_rw", bus.wb_reg_write, 1);

    // Decode spot checks
    drive(1'b1, OPC_OPIMM, 3'b101, 1'b1, 1'b0, 1'b0);
    tick();
    chk("srai_op", bus.ex_alu_op, A_SRA);
    chk("srai_rr", bus.ex_reg_reg_inst, 0);
    drive(1'b1, OPC_OP, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sub_op", bus.ex_alu_op, A_SUB);
    drive(1'b1, OPC_BRANCH, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_op", bus.ex_alu_op, A_SUB);
    chk("br_flag", bus.ex_branch_inst, 1);
    drive(1'b1, OPC_JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("jal_flag", bus.ex_jump_inst, 1);
    chk("jal_op", bus.ex_alu_op, A_ADD);
    chk("br_mem_rw", bus.mem_reg_write, 0);
    drive(1'b1, OPC_LUI, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lui_op", bus.ex_alu_op, A_AUI);
    chk("jal_mem_rw", bus.mem_reg_write, 1);
    drive(1'b1, 7'b0000001, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lo2_ill", bus.ex_illegal, 1);
    chk("lo2_op", bus.ex_alu_op, A_NOP);
    drive(1'b1, OPC_OP, 3'b001, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mulf3_ill", bus.ex_illegal, 1);
    chk("mulf3_busy", bus.mc_busy, 0);

    // Illegal opcode 0
    drive(1'b1, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    chk("ill0_valid", bus.ex_valid, 1);
    chk("ill0_ill", bus.ex_illegal, 1);
    chk("ill0_op", bus.ex_alu_op, A_NOP);
    chk("ill0_busy", bus.mc_busy, 0);
    tick();
    chk("ill0_mem_valid", bus.mem_valid, 1);
    chk("ill0_mem_rw", bus.mem_reg_write, 0);
    chk("ill0_mem_ld", bus.mem_load_inst, 0);
    tick();

    // DIV
    drive(1'b1, OPC_OP, 3'b100, 1'b0, 1'b1, 1'b0);
    tick(); idle();
`ifdef CU_DIV_EN
    chk("div_op", bus.ex_alu_op, 14);
    chk("div_busy", bus.mc_busy, 1);
    chk("div_ready", bus.id_ready, 0);
    repeat (4) tick();
    chk("div_b5_busy", bus.mc_busy, 1);
    drive(1'b0, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1);
    tick(); idle();
    chk("divfl_ex_valid", bus.ex_valid, 0);
    chk("divfl_busy", bus.mc_busy, 0);
    chk("divfl_ready", bus.id_ready, 1);
    chk("divfl_mem", bus.mem_valid, 0);
    tick();
    chk("divfl_mem_never", bus.mem_valid, 0);
`else
    chk("div_ill", bus.ex_illegal, 1);
    chk("div_op", bus.ex_alu_op, A_NOP);
    chk("div_busy", bus.mc_busy, 0);
    chk("div_ready", bus.id_ready, 1);
    tick();
    chk("div_mem_rw", bus.mem_reg_write, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised successor to the single-stage decoder.
- Decodes RV32IM opcode/funct fields into control words and carries them through EX, MEM and WB pipeline registers, so no later stage re-derives control.
- Adds branch/jump/store/illegal decode, multi-cycle MUL/DIV stall sequencing with an ID-side ready handshake, and a pipeline flush.
- Sits between the ID stage and the EX/MEM/WB datapath.

Parameters:
ALU_OP_W, 5, width of alu_op; encodings are the inst_pkg values (NOP, ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, AUI, AUIPC, MUL, DIV)
MUL_CYCLES, 3, EX occupancy of MUL in cycles (>=1; 1 = no stall)
DIV_CYCLES, 16, EX occupancy of DIV in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID presents an instruction
id_ready  out  1  control unit accepts the instruction this cycle
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7_b5  in  1  instruction[30]
mul_inst  in  1  funct7 == 7'h01
flush  in  1  kill ID-capture and EX stage (redirect)
ex_valid  out  1  EX stage holds a live instruction
ex_alu_op  out  ALU_OP_W  EX ALU operation
ex_branch_inst, ex_jump_inst, ex_reg_reg_inst  out  1 each  EX class flags
ex_illegal  out  1  EX instruction failed decode
mem_valid, mem_load_inst, mem_store_inst, mem_reg_write  out  1 each  MEM stage control
wb_valid, wb_load_inst, wb_reg_write  out  1 each  WB stage control
mc_busy  out  1  multi-cycle op occupying EX

Behaviour:
- Reset (async assert, sync release): all ex_/mem_/wb_ outputs 0, ex_alu_op = NOP, FSM = IDLE, counter = 0, mc_busy = 0.
- Decode (combinational, sampled on capture):
  - opcode[1:0] != 2'b11: NOP, illegal = 1.
  - Loads (0000011): load + reg_write, ADD.
  - OP-IMM (0010011): funct3 map; funct3 = 101 selects SRA when funct7_b5 = 1, else SRL.
  - AUIPC (0010111): AUIPC, reg_write.
  - LUI (0110111): AUI, reg_write.
  - STORE (0100011): store, ADD, no reg_write.
  - OP (0110011):
    - mul_inst = 0: ADD/SUB (SUB when funct7_b5 = 1), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
    - mul_inst = 1: funct3 000 = MUL, 100 = DIV; any other funct3 = NOP, illegal.
  - BRANCH (1100011): branch, SUB, no reg_write.
  - JAL (1101111) / JALR (1100111): jump, ADD, reg_write.
  - Any other opcode: NOP, illegal.
  - An illegal instruction never asserts reg_write, load or store.
- Capture and advance:
  - id_valid & id_ready loads the decoded word into EX (ex_valid = 1) on the next edge.
  - Otherwise EX loads a bubble (valid = 0, NOP).
  - Each cycle EX advances to MEM and MEM to WB, except as noted under the FSM.
  - Latency from capture to WB: 3 cycles for single-cycle ops.
- FSM:
  - IDLE: id_ready = 1. If the captured op is MUL with MUL_CYCLES > 1, or DIV with DIV_CYCLES > 1, load counter with N-2 and go to BUSY.
  - BUSY: id_ready = 0, mc_busy = 1, EX holds its contents, MEM receives a bubble each cycle. When counter = 0, the next edge advances EX to MEM and returns to IDLE; otherwise decrement.
  - Result: EX occupancy is exactly N cycles. Back-to-back MULs are accepted on the first IDLE cycle.
- Flush:
  - Next edge: EX becomes a bubble, the ID instruction is not captured, FSM = IDLE, counter cleared.
  - MEM/WB are unaffected and still advance normally.
  - Flush has priority over simultaneous id_valid and over BUSY completion.
- Reset mid-operation aborts BUSY immediately.
- id_ready is combinational from FSM state only and is independent of id_valid.

Optional Feature:
- CU_DIV_EN defined: DIV is decoded with DIV_CYCLES occupancy.
- CU_DIV_EN undefined: mul_inst & funct3 = 100 decodes as NOP with illegal = 1 and never enters BUSY. DIV_CYCLES is then unused.

Test Plan:
- Reset low mid-stream, then high → all valids 0, ex_alu_op = NOP, id_ready = 1 on the first cycle.
- ADD x1,x2,x3 (opcode 0110011, funct3 000, b5 0) captured at cycle 0 → ex_alu_op = ADD at cycle 1; mem_reg_write = 1 at cycle 2; wb_reg_write = 1 at cycle 3.
- MUL, MUL_CYCLES = 3, followed by ADD held on id_valid → id_ready = 0 for 2 cycles, mc_busy = 1 for 2 cycles, MEM gets 2 bubbles; ADD is accepted on the 3rd cycle and follows MUL by one cycle into MEM.
- flush during a DIV (DIV_CYCLES = 16) at busy cycle 5 → next cycle ex_valid = 0, mc_busy = 0, id_ready = 1; the DIV never reaches MEM.
- Store (0100011), then load (0000011) → mem_store_inst = 1 with mem_reg_write = 0, then mem_load_inst = 1 with wb_reg_write = 1 one cycle later.
- opcode 7'b0000000, and mul_inst with funct3 = 100 with CU_DIV_EN undefined → ex_illegal = 1, ex_alu_op = NOP, no reg_write, no stall.
